// File: rtl/spi_ctl_pkg.sv
// Shared types and constants for the SPI master arbiter/sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package spi_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STROBE = 3'd1,
        ST_XFER   = 3'd2,
        ST_RDCAP  = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    // SCLK-divider 0 shifts one byte in this many core cycles
    localparam int XFER_BASE = 16;

    // Core cycles the master needs to shift one byte at the given divider (16/32/64/128)
    function automatic logic [7:0] xfer_cycles(input logic [1:0] div);
        return 8'(XFER_BASE << div);
    endfunction

endpackage

// File: rtl/spi_master_arbiter_rr_arb2.sv
// Two-way round-robin arbiter producing a one-hot grant.
// Latency: purely combinational.
// Backpressure: grant is zero unless i_accept is high.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    // On contention favour the requester that did not win last; a lone requester always wins
    always_comb begin
        o_grant = 2'b00;
        if (i_accept) begin
            if (i_valid == 2'b11) begin
                o_grant = i_last_grant ? 2'b01 : 2'b10;
            end else begin
                o_grant = i_valid;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Arbitrates two command clients onto the SPI byte engine and times each transfer by cycle count.
// Latency: strobe 1 cycle after accept; read data 3 cycles after accept; write occupies 1+16<<div cycles.
// Backpressure: reqN_ready only in IDLE for the arbitration winner; GUARD idle cycles after every transaction.
module spi_master_arbiter
    import spi_ctl_pkg::*;
#(
    parameter int GUARD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rd,
    input  logic [7:0] req0_data,
    input  logic [1:0] req0_div,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rd,
    input  logic [7:0] req1_data,
    input  logic [1:0] req1_div,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       spi_cs,
    output logic       spi_wr,
    output logic       spi_rd,
    output logic [7:0] spi_in_data,
    output logic [1:0] spi_div,
    input  logic [7:0] spi_out_data
);

    localparam logic [7:0] GAP_LOAD = 8'(GUARD - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_cnt;
    logic       r_rd;
    logic [7:0] r_data;
    logic [1:0] r_div;
    logic       r_id;
    logic       r_last_grant;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [7:0] r_rsp_data;

    logic       w_accept_en;
    logic [1:0] w_grant;
    logic       w_take;
    logic       w_take_id;
    logic       w_spi_cs;
    logic       w_spi_wr;
    logic       w_spi_rd;

    // Ready is gated by reset so nothing is accepted while the block is held in reset
    assign w_accept_en = (r_state == ST_IDLE) && !rst;

    rr_arb2 u_arb (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .i_accept     (w_accept_en),
        .o_grant      (w_grant)
    );

    assign w_take     = |w_grant;
    assign w_take_id  = w_grant[1];
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and master strobe decode; strobes exist only in the single STROBE cycle
    always_comb begin
        w_next_state = r_state;
        w_spi_cs     = 1'b0;
        w_spi_wr     = 1'b0;
        w_spi_rd     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_next_state = ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_spi_cs = 1'b1;
                if (r_rd) begin
                    w_spi_rd     = 1'b1;
                    w_next_state = ST_RDCAP;
                end else begin
                    w_spi_wr     = 1'b1;
                    w_next_state = ST_XFER;
                end
            end
            ST_XFER: begin
                if (r_cnt == 8'd0) begin
                    w_next_state = ST_GAP;
                end
            end
            ST_RDCAP: begin
                w_next_state = ST_GAP;
            end
            ST_GAP: begin
                if (r_cnt == 8'd0) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Capture the winning command; these registers also drive the master's data/divider inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd         <= 1'b0;
            r_data       <= 8'd0;
            r_div        <= 2'd0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_take) begin
            r_rd         <= w_take_id ? req1_rd   : req0_rd;
            r_data       <= w_take_id ? req1_data : req0_data;
            r_div        <= w_take_id ? req1_div  : req0_div;
            r_id         <= w_take_id;
            r_last_grant <= w_take_id;
        end
    end

    // Shared down-counter: transfer length during XFER, then guard length during GAP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_STROBE: begin
                    if (!r_rd) begin
                        r_cnt <= xfer_cycles(r_div) - 8'd1;
                    end
                end
                ST_XFER: begin
                    r_cnt <= (r_cnt == 8'd0) ? GAP_LOAD : r_cnt - 8'd1;
                end
                ST_RDCAP: begin
                    r_cnt <= GAP_LOAD;
                end
                ST_GAP: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Read response: sample the master's byte in RDCAP and pulse valid the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= 8'd0;
        end else begin
            r_rsp_valid <= (r_state == ST_RDCAP);
            if (r_state == ST_RDCAP) begin
                r_rsp_id   <= r_id;
                r_rsp_data <= spi_out_data;
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_data    = r_rsp_data;
    assign busy        = (r_state != ST_IDLE);
    assign spi_cs      = w_spi_cs;
    assign spi_wr      = w_spi_wr;
    assign spi_rd      = w_spi_rd;
    assign spi_in_data = r_data;
    assign spi_div     = r_div;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Testbench for spi_master_arbiter: directed stimulus with a queue-based scoreboard.
// Latency: n/a.
// Backpressure: requesters hold valid until accepted.
module tb_spi_master_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_rd, req0_ready;
    logic [7:0] req0_data;
    logic [1:0] req0_div;
    logic       req1_valid, req1_rd, req1_ready;
    logic [7:0] req1_data;
    logic [1:0] req1_div;
    logic       rsp_valid, rsp_id;
    logic [7:0] rsp_data;
    logic       busy, spi_cs, spi_wr, spi_rd;
    logic [7:0] spi_in_data;
    logic [1:0] spi_div;
    logic [7:0] spi_out_data;

    typedef struct {int cyc; logic rd; logic [7:0] data; logic [1:0] div;} strobe_t;
    typedef struct {int cyc; logic id; logic [7:0] data;} rsp_t;
    typedef struct {int cyc; logic id;} acc_t;

    strobe_t sq[$];
    rsp_t    rq[$];
    acc_t    acc_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    spi_master_arbiter #(.GUARD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_rd      (req0_rd),
        .req0_data    (req0_data),
        .req0_div     (req0_div),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_rd      (req1_rd),
        .req1_data    (req1_data),
        .req1_div     (req1_div),
        .req1_ready   (req1_ready),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .spi_cs       (spi_cs),
        .spi_wr       (spi_wr),
        .spi_rd       (spi_rd),
        .spi_in_data  (spi_in_data),
        .spi_div      (spi_div),
        .spi_out_data (spi_out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Acceptance monitor pushes expectations; output monitor pops and compares
    strobe_t m_s;
    rsp_t    m_r;
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready && req1_valid && req1_ready) begin
                check("grant_onehot", 32'd2, 32'd1);
            end
            if (req0_valid && req0_ready) begin
                acc_q.push_back('{cyc, 1'b0});
                sq.push_back('{cyc + 1, req0_rd, req0_data, req0_div});
                if (req0_rd) rq.push_back('{cyc + 3, 1'b0, spi_out_data});
            end
            if (req1_valid && req1_ready) begin
                acc_q.push_back('{cyc, 1'b1});
                sq.push_back('{cyc + 1, req1_rd, req1_data, req1_div});
                if (req1_rd) rq.push_back('{cyc + 3, 1'b1, spi_out_data});
            end
            if (spi_cs || spi_wr || spi_rd) begin
                if (sq.size() == 0) begin
                    check("strobe_unexpected", {spi_cs, spi_wr, spi_rd}, 32'd0);
                end else begin
                    m_s = sq.pop_front();
                    check("strobe_cycle", cyc, m_s.cyc);
                    check("strobe_ctl", {spi_cs, spi_wr, spi_rd, spi_div},
                          {1'b1, !m_s.rd, m_s.rd, m_s.div});
                    if (!m_s.rd) check("strobe_data", spi_in_data, m_s.data);
                end
            end
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 32'd0);
                end else begin
                    m_r = rq.pop_front();
                    check("rsp_cycle", cyc, m_r.cyc);
                    check("rsp_id_data", {rsp_id, rsp_data}, {m_r.id, m_r.data});
                end
            end
        end
    end

    task automatic wait_accept(output logic id, output int t);
        int n = 0;
        while (acc_q.size() == 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (acc_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: no acceptance within 400 cycles (cycle %0d)", cyc);
            id = 1'b0;
            t  = -1000;
        end else begin
            acc_t a;
            a  = acc_q.pop_front();
            id = a.id;
            t  = a.cyc;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        #1;
        while (busy && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (busy) begin
            n_checks++;
            n_err++;
            $display("FAIL idle_timeout: busy still high after 400 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic id;
        int   t, t2, tp, nb, rel;

        rst = 1'b1;
        spi_out_data = 8'h5C;
        req0_valid = 1'b1; req0_rd = 1'b0; req0_data = 8'h11; req0_div = 2'd0;
        req1_valid = 1'b1; req1_rd = 1'b0; req1_data = 8'h22; req1_div = 2'd0;

        // Reset held 3 cycles with both requesters pending
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs",
              {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, busy,
               spi_cs, spi_wr, spi_rd, spi_in_data, spi_div}, 32'd0);
        next_cycle();
        rst = 1'b0;
        rel = cyc;
        wait_accept(id, t);
        check("first_grant_id", id, 1'b0);
        check("first_grant_cycle", t, rel);
        next_cycle();
        req0_valid = 1'b0;
        wait_accept(id, t2);
        check("second_grant_id", id, 1'b1);
        check("second_grant_gap", t2 - t, 22);
        next_cycle();
        req1_valid = 1'b0;
        wait_idle();

        // req0 write 0xCA div0: busy length and earliest re-accept
        next_cycle();
        req0_valid = 1'b1; req0_rd = 1'b0; req0_data = 8'hCA; req0_div = 2'd0;
        wait_accept(id, t);
        check("ca_grant_id", id, 1'b0);
        nb = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
            nb++;
        end
        check("ca_busy_len", nb, 21);
        wait_accept(id, t2);
        check("ca_reaccept_id", id, 1'b0);
        check("ca_reaccept_gap", t2 - t, 22);
        next_cycle();
        req0_valid = 1'b0;
        wait_idle();

        // req1 read: response three cycles after accept, re-accept after guard
        next_cycle();
        req1_valid = 1'b1; req1_rd = 1'b1; req1_data = 8'hFF; req1_div = 2'd2;
        wait_accept(id, t);
        check("rd_grant_id", id, 1'b1);
        wait_accept(id, t2);
        check("rd_reaccept_id", id, 1'b1);
        check("rd_reaccept_gap", t2 - t, 7);
        next_cycle();
        req1_valid = 1'b0;
        wait_idle();

        // Contention: both write continuously, last grant was req1
        next_cycle();
        req0_valid = 1'b1; req0_rd = 1'b0; req0_data = 8'h51; req0_div = 2'd0;
        req1_valid = 1'b1; req1_rd = 1'b0; req1_data = 8'hA3; req1_div = 2'd0;
        tp = 0;
        for (int k = 0; k < 4; k++) begin
            wait_accept(id, t);
            check("contend_id", id, 32'(k % 2));
            if (k > 0) check("contend_gap", t - tp, 22);
            tp = t;
        end
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // div=3 write: 128-cycle transfer, next accept at T+134
        next_cycle();
        req0_valid = 1'b1; req0_rd = 1'b0; req0_data = 8'h3C; req0_div = 2'd3;
        wait_accept(id, t);
        check("div3_grant_id", id, 1'b0);
        wait_accept(id, t2);
        check("div3_reaccept_id", id, 1'b0);
        check("div3_reaccept_gap", t2 - t, 134);
        next_cycle();
        req0_valid = 1'b0;
        wait_idle();

        // Reset during the fifth XFER cycle, req1 waiting
        next_cycle();
        req0_valid = 1'b1; req0_rd = 1'b0; req0_data = 8'h96; req0_div = 2'd1;
        wait_accept(id, t);
        check("abort_grant_id", id, 1'b0);
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_rd = 1'b0; req1_data = 8'h77; req1_div = 2'd0;
        repeat (5) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("abort_outputs", {spi_cs, spi_wr, spi_rd, busy, rsp_valid}, 32'd0);
        check("abort_ready1", req1_ready, 1'b1);
        wait_accept(id, t2);
        check("abort_regrant_id", id, 1'b1);
        check("abort_regrant_cycle", t2 - t, 7);
        next_cycle();
        req1_valid = 1'b0;
        wait_idle();

        check("strobe_queue_empty", sq.size(), 32'd0);
        check("rsp_queue_empty", rq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
